// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e : which requester owns the outstanding memory transaction
//   cnt_width() : width needed for a counter that must hold 0..max_val
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio2.sv
// Two-way priority pick between fetch (I) and data (D) with a starvation guard.
// D normally wins; once D has been granted STARVE_LIMIT times in a row while I
// was waiting, I is forced to win the next pick.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   en_i                 picking allowed this cycle (arbiter idle)
//   i_valid_i, d_valid_i requester valids
//   grant_i_o, grant_d_o combinational one-hot grant (0 when en_i low)
module mem_port_arbiter_arb_prio2
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic i_valid_i,
    input  logic d_valid_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             force_i;

    assign force_i   = i_valid_i && (starve_q == CNT_W'(STARVE_LIMIT));
    assign grant_i_o = en_i && i_valid_i && (force_i || !d_valid_i);
    assign grant_d_o = en_i && d_valid_i && !force_i;

    // Count D grants that overtook a waiting I; any I grant clears, saturates at limit.
    always_comb begin
        starve_d = starve_q;
        if (grant_i_o) begin
            starve_d = '0;
        end else if (grant_d_o && i_valid_i && (starve_q != CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and the data stage (D).
// One transaction outstanding at a time; its response is routed to the owner.
// Optional build macro: MEM_TIMEOUT_EN enables a response watchdog of
// TIMEOUT_CYC cycles that completes the transaction with an error response.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req_*                    fetch request (read only), valid/allow handshake
//   i_resp_*                   fetch response pulse, read data, error
//   d_req_*                    data request (load/store), valid/allow handshake
//   d_resp_*                   data response pulse, read data, error
//   mem_req_*                  request to memory, fields held while pending
//   mem_resp_valid/_rdata      memory response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                i_req_allow,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_resp_valid,
    output logic [DATA_W-1:0]   i_resp_rdata,
    output logic                i_resp_err,
    input  logic                d_req_valid,
    output logic                d_req_allow,
    input  logic                d_req_wr,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_rdata,
    output logic                d_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_allow,
    output logic                mem_req_wr,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q;
    state_e              state_d;
    owner_e              owner_q;
    logic                wr_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                i_rv_q;
    logic                d_rv_q;
    logic                i_err_q;
    logic                d_err_q;
    logic                arb_en;
    logic                grant_i;
    logic                grant_d;
    logic                resp_fire;
    logic                timeout_c;

    // Grants only from IDLE and never while reset is applied.
    assign arb_en    = (state_q == ST_IDLE) && !reset;
    assign resp_fire = (state_q == ST_WAIT) && mem_resp_valid;

    mem_port_arbiter_arb_prio2 #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (arb_en),
        .i_valid_i (i_req_valid),
        .d_valid_i (d_req_valid),
        .grant_i_o (grant_i),
        .grant_d_o (grant_d)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO_W = cnt_width(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;

    // Cycles spent in ISSUE+WAIT; a real response in the same cycle takes precedence.
    always_comb begin
        to_cnt_d = '0;
        if (state_q != ST_IDLE) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout_c = (state_q != ST_IDLE) && !resp_fire
                       && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_i || grant_d) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (timeout_c)          state_d = ST_IDLE;
                else if (mem_req_allow) state_d = ST_WAIT;
            end
            ST_WAIT:  if (resp_fire || timeout_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        i_req_allow   = grant_i;
        d_req_allow   = grant_d;
        mem_req_valid = (state_q == ST_ISSUE) && !reset;
    end

    // Request latch and response pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            i_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
        end else begin
            i_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            i_err_q <= 1'b0;
            d_err_q <= 1'b0;
            if (grant_i) begin
                owner_q <= OWN_I;
                wr_q    <= 1'b0;
                wstrb_q <= '0;
                addr_q  <= i_req_addr;
                wdata_q <= '0;
            end else if (grant_d) begin
                owner_q <= OWN_D;
                wr_q    <= d_req_wr;
                wstrb_q <= d_req_wstrb;
                addr_q  <= d_req_addr;
                wdata_q <= d_req_wdata;
            end
            if (resp_fire) begin
                rdata_q <= mem_resp_rdata;
                i_rv_q  <= (owner_q == OWN_I);
                d_rv_q  <= (owner_q == OWN_D);
            end else if (timeout_c) begin
                rdata_q <= '0;
                i_rv_q  <= (owner_q == OWN_I);
                d_rv_q  <= (owner_q == OWN_D);
                i_err_q <= (owner_q == OWN_I);
                d_err_q <= (owner_q == OWN_D);
            end
        end
    end

    assign mem_req_wr    = wr_q;
    assign mem_req_wstrb = wstrb_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign i_resp_valid  = i_rv_q;
    assign i_resp_rdata  = rdata_q;
    assign i_resp_err    = i_err_q;
    assign d_resp_valid  = d_rv_q;
    assign d_resp_rdata  = rdata_q;
    assign d_resp_err    = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT_CYC=8).
// Each vector drives one cycle of inputs and checks the outputs at the falling edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    // Expected flag bits: {i_allow, d_allow, mem_valid, i_rv, i_err, d_rv, d_err}
    localparam logic [6:0] F_IA = 7'b1000000;
    localparam logic [6:0] F_DA = 7'b0100000;
    localparam logic [6:0] F_MV = 7'b0010000;
    localparam logic [6:0] F_IR = 7'b0001000;
    localparam logic [6:0] F_IE = 7'b0000100;
    localparam logic [6:0] F_DR = 7'b0000010;
    localparam logic [6:0] F_NO = 7'b0000000;

    typedef struct packed {
        logic          rst;
        logic          iv;
        logic [AW-1:0] ia;
        logic          dv;
        logic          dwr;
        logic [SW-1:0] ds;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          ma;
        logic          mrv;
        logic [DW-1:0] mrd;
    } stim_t;

    typedef struct packed {
        logic [6:0]    flags;
        logic          mwr;
        logic [SW-1:0] ms;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic [DW-1:0] rdata;
        logic          full;
    } want_t;

    typedef struct packed {
        stim_t stim;
        want_t want;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          i_req_valid, i_req_allow;
    logic [AW-1:0] i_req_addr;
    logic          i_resp_valid, i_resp_err;
    logic [DW-1:0] i_resp_rdata;
    logic          d_req_valid, d_req_allow, d_req_wr;
    logic [SW-1:0] d_req_wstrb;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_resp_valid, d_resp_err;
    logic [DW-1:0] d_resp_rdata;
    logic          mem_req_valid, mem_req_allow, mem_req_wr;
    logic [SW-1:0] mem_req_wstrb;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_rdata;

    int n_vec;
    int n_bad;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (4),
        .TIMEOUT_CYC  (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req_valid    (i_req_valid),
        .i_req_allow    (i_req_allow),
        .i_req_addr     (i_req_addr),
        .i_resp_valid   (i_resp_valid),
        .i_resp_rdata   (i_resp_rdata),
        .i_resp_err     (i_resp_err),
        .d_req_valid    (d_req_valid),
        .d_req_allow    (d_req_allow),
        .d_req_wr       (d_req_wr),
        .d_req_wstrb    (d_req_wstrb),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_resp_rdata   (d_resp_rdata),
        .d_resp_err     (d_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_allow  (mem_req_allow),
        .mem_req_wr     (mem_req_wr),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(input logic rst, input logic iv, input logic [AW-1:0] ia,
                                 input logic dv, input logic dwr, input logic [SW-1:0] ds,
                                 input logic [AW-1:0] da, input logic [DW-1:0] dd,
                                 input logic ma, input logic mrv, input logic [DW-1:0] mrd);
        stim_t s;
        s.rst = rst; s.iv = iv; s.ia = ia; s.dv = dv; s.dwr = dwr; s.ds = ds;
        s.da = da; s.dd = dd; s.ma = ma; s.mrv = mrv; s.mrd = mrd;
        return s;
    endfunction

    function automatic stim_t s_idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t s_i(input logic [AW-1:0] a);
        return st(0, 1, a, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t s_m(input logic ma, input logic mrv, input logic [DW-1:0] mrd);
        return st(0, 0, 0, 0, 0, 0, 0, 0, ma, mrv, mrd);
    endfunction

    function automatic want_t wv(input logic [6:0] f, input logic mwr, input logic [SW-1:0] ms,
                                 input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                                 input logic [DW-1:0] rd, input logic full);
        want_t w;
        w.flags = f; w.mwr = mwr; w.ms = ms; w.maddr = ma; w.mwd = mwd; w.rdata = rd; w.full = full;
        return w;
    endfunction

    function automatic want_t w_f(input logic [6:0] f);
        return wv(f, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic want_t w_m(input logic [6:0] f, input logic mwr, input logic [SW-1:0] ms,
                                  input logic [AW-1:0] ma, input logic [DW-1:0] mwd);
        return wv(f, mwr, ms, ma, mwd, 0, 0);
    endfunction

    function automatic want_t w_r(input logic [6:0] f, input logic [DW-1:0] rd);
        return wv(f, 0, 0, 0, 0, rd, 0);
    endfunction

    function automatic vec_t mk(input stim_t s, input want_t w);
        vec_t v;
        v.stim = s;
        v.want = w;
        return v;
    endfunction

    // Drive one cycle, compare at the falling edge, return 1ns after the next rising edge.
    task automatic apply(input string nm, input stim_t s, input want_t w);
        logic [6:0] af;
        logic       bad;
        reset          = s.rst;
        i_req_valid    = s.iv;
        i_req_addr     = s.ia;
        d_req_valid    = s.dv;
        d_req_wr       = s.dwr;
        d_req_wstrb    = s.ds;
        d_req_addr     = s.da;
        d_req_wdata    = s.dd;
        mem_req_allow  = s.ma;
        mem_resp_valid = s.mrv;
        mem_resp_rdata = s.mrd;
        @(negedge clk);
        af  = {i_req_allow, d_req_allow, mem_req_valid, i_resp_valid, i_resp_err,
               d_resp_valid, d_resp_err};
        bad = (af != w.flags);
        if (w.full || w.flags[4])
            bad = bad || (mem_req_wr != w.mwr) || (mem_req_wstrb != w.ms)
                      || (mem_req_addr != w.maddr) || (mem_req_wdata != w.mwd);
        if (w.full || w.flags[3]) bad = bad || (i_resp_rdata != w.rdata);
        if (w.full || w.flags[1]) bad = bad || (d_resp_rdata != w.rdata);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: flags got %b want %b; mem wr/strb/addr/wdata got %b/%h/%h/%h want %b/%h/%h/%h; rdata got i=%h d=%h want %h",
                     nm, af, w.flags, mem_req_wr, mem_req_wstrb, mem_req_addr, mem_req_wdata,
                     w.mwr, w.ms, w.maddr, w.mwd, i_resp_rdata, d_resp_rdata, w.rdata);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t  tbl [15];
    stim_t s_st;

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        i_req_valid = 0; i_req_addr = '0;
        d_req_valid = 0; d_req_wr = 0; d_req_wstrb = '0; d_req_addr = '0; d_req_wdata = '0;
        mem_req_allow = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset, single fetch, D-over-I store, response then grant in the same cycle.
        tbl[0]  = mk(st(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0), w_f(F_NO));
        tbl[1]  = mk(s_idle(), wv(F_NO, 0, 0, 0, 0, 0, 1));
        tbl[2]  = mk(s_i(32'h100), w_f(F_IA));
        tbl[3]  = mk(s_m(1, 0, 0), w_m(F_MV, 0, 4'b0000, 32'h100, 0));
        tbl[4]  = mk(s_m(0, 1, 32'hDEADBEEF), w_f(F_NO));
        tbl[5]  = mk(s_idle(), w_r(F_IR, 32'hDEADBEEF));
        tbl[6]  = mk(s_m(0, 1, 32'h0000_1234), w_f(F_NO));
        tbl[7]  = mk(st(0, 1, 32'h200, 1, 1, 4'b0011, 32'h40, 32'h12345678, 0, 0, 0), w_f(F_DA));
        tbl[8]  = mk(st(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0), w_m(F_MV, 1, 4'b0011, 32'h40, 32'h12345678));
        tbl[9]  = mk(st(0, 1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0), w_m(F_MV, 1, 4'b0011, 32'h40, 32'h12345678));
        tbl[10] = mk(st(0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D), w_f(F_NO));
        tbl[11] = mk(s_i(32'h200), w_r(F_IA | F_DR, 32'h0BADF00D));
        tbl[12] = mk(s_m(1, 0, 0), w_m(F_MV, 0, 4'b0000, 32'h200, 0));
        tbl[13] = mk(s_m(0, 1, 32'h11111111), w_f(F_NO));
        tbl[14] = mk(s_idle(), w_r(F_IR, 32'h11111111));
        for (int k = 0; k < 15; k++) apply($sformatf("vec%0d", k), tbl[k].stim, tbl[k].want);

        // Starvation: D valid in every IDLE cycle with I held; four D grants then I.
        s_st = st(0, 1, 32'h400, 1, 0, 0, 32'h300, 0, 1, 1, 32'h55);
        for (int g = 0; g < 6; g++) begin
            logic [6:0] f;
            f = (g == 4) ? F_IA : F_DA;
            if (g >= 1 && g <= 4) f = f | F_DR;
            if (g == 5) f = f | F_IR;
            apply($sformatf("starve_grant%0d", g), s_st, w_r(f, 32'h55));
            apply($sformatf("starve_issue%0d", g), s_st,
                  w_m(F_MV, 0, 0, (g == 4) ? 32'h400 : 32'h300, 0));
            apply($sformatf("starve_wait%0d", g), (g == 5) ? s_m(1, 1, 32'h55) : s_st, w_f(F_NO));
        end
        apply("starve_last_resp", s_idle(), w_r(F_DR, 32'h55));

        // Memory stalls request acceptance for 5 cycles.
        apply("stall_grant", st(0, 0, 0, 1, 0, 0, 32'h500, 0, 0, 0, 0), w_f(F_DA));
        for (int c = 0; c < 5; c++)
            apply($sformatf("stall_hold%0d", c),
                  st(0, 1, 32'h600, 1, 1, 4'b1111, 32'h999, 32'hFFFF, 0, 1, 32'hAA),
                  w_m(F_MV, 0, 0, 32'h500, 0));
        apply("stall_accept", s_m(1, 0, 0), w_m(F_MV, 0, 0, 32'h500, 0));
        apply("stall_wait0", s_idle(), w_f(F_NO));
        apply("stall_wait1", s_idle(), w_f(F_NO));
        apply("stall_memresp", s_m(0, 1, 32'h77), w_f(F_NO));
        apply("stall_resp", s_idle(), w_r(F_DR, 32'h77));

        // Reset while waiting for the response abandons the transaction.
        apply("rst_grant", s_i(32'h600), w_f(F_IA));
        apply("rst_issue", s_m(1, 0, 0), w_m(F_MV, 0, 0, 32'h600, 0));
        apply("rst_in_wait", st(1, 1, 32'h600, 0, 0, 0, 0, 0, 0, 1, 32'h99), w_f(F_NO));
        apply("rst_after", s_idle(), wv(F_NO, 0, 0, 0, 0, 0, 1));
        apply("rst_quiet", s_idle(), w_f(F_NO));
        apply("rst_new_grant", s_i(32'h700), w_f(F_IA));
        apply("rst_new_issue", s_m(1, 0, 0), w_m(F_MV, 0, 0, 32'h700, 0));
        apply("rst_new_memresp", s_m(0, 1, 32'hCAFE0001), w_f(F_NO));
        apply("rst_new_resp", s_idle(), w_r(F_IR, 32'hCAFE0001));

`ifdef MEM_TIMEOUT_EN
        // No memory response: error response after 8 cycles in ISSUE+WAIT.
        apply("to_grant", s_i(32'h800), w_f(F_IA));
        apply("to_issue", s_m(1, 0, 0), w_m(F_MV, 0, 0, 32'h800, 0));
        for (int c = 0; c < 7; c++) apply($sformatf("to_wait%0d", c), s_idle(), w_f(F_NO));
        apply("to_err_resp", s_idle(), w_r(F_IR | F_IE, 32'h0));
        apply("to_late_resp", s_m(0, 1, 32'hBEEF), w_f(F_NO));
        apply("to_late_ignored", s_idle(), w_f(F_NO));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
